// File: rtl/aes_key_expansion.sv
// AES-128 key schedule engine.
// Expands a 128-bit cipher key into 11 round keys, one 32-bit word per clock.
// Round keys are streamed on o_rk_valid and kept in an 11-entry table that the
// round datapath reads combinationally through i_rk_addr / o_rk_data.

// Combinational AES byte S-box.
module subBytes (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  // Row-major S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b occupies bits [8*(255-b)+7 -: 8], i.e. top bit index {~b, 3'b111}.
  logic [10:0] w_idx;

  assign w_idx    = {~byte_in, 3'b111};
  assign byte_out = SBOX[w_idx -: 8];

endmodule

module aes_key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key_in,
  output logic         o_busy,
  output logic         o_rk_valid,
  output logic [3:0]   o_rk_index,
  output logic [127:0] o_rk_out,
  output logic         o_done,
  input  logic [3:0]   i_rk_addr,
  output logic [127:0] o_rk_data
);

  // S_LAST holds busy high for the cycle in which round 10 and done are shown,
  // so a start arriving alongside done is ignored.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_LAST   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [5:0]    r_cnt;
  logic [31:0]   r_w0;
  logic [31:0]   r_w1;
  logic [31:0]   r_w2;
  logic [31:0]   r_w3;
  logic [7:0]    r_rcon;
  logic [127:0]  r_table [0:10];
  logic          r_rk_valid;
  logic [3:0]    r_rk_index;
  logic [127:0]  r_rk_out;
  logic          r_done;

  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic          w_first_of_round;
  logic          w_last_of_round;
  logic          w_last_word;
  logic [7:0]    w_rcon_next;
  logic [127:0]  w_rk_data;

  // RotWord then SubWord on the newest window word.
  assign w_rot = {r_w3[23:0], r_w3[31:24]};

  subBytes u_sb3 (.byte_in(w_rot[31:24]), .byte_out(w_sub[31:24]));
  subBytes u_sb2 (.byte_in(w_rot[23:16]), .byte_out(w_sub[23:16]));
  subBytes u_sb1 (.byte_in(w_rot[15:8]),  .byte_out(w_sub[15:8]));
  subBytes u_sb0 (.byte_in(w_rot[7:0]),   .byte_out(w_sub[7:0]));

  assign w_first_of_round = (r_cnt[1:0] == 2'd0);
  assign w_last_of_round  = (r_cnt[1:0] == 2'd3);
  assign w_last_word      = (r_cnt == 6'd43);
  assign w_temp           = w_first_of_round ? (w_sub ^ {r_rcon, 24'h0}) : r_w3;
  assign w_new            = r_w0 ^ w_temp;
  assign w_rcon_next      = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> EXPAND on start, EXPAND -> LAST after w43.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_EXPAND;
      S_EXPAND: if (w_last_word) w_next_state = S_LAST;
      S_LAST:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Busy output decoded from state.
  always_comb begin
    o_busy = 1'b0;
    if (r_state != S_IDLE) o_busy = 1'b1;
  end

  // Word window, rcon, round-key table and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_w0       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_w3       <= '0;
      r_rcon     <= 8'h01;
      r_rk_valid <= 1'b0;
      r_rk_index <= '0;
      r_rk_out   <= '0;
      r_done     <= 1'b0;
      for (int k = 0; k < 11; k++) r_table[k] <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_w0       <= i_key_in[127:96];
            r_w1       <= i_key_in[95:64];
            r_w2       <= i_key_in[63:32];
            r_w3       <= i_key_in[31:0];
            r_cnt      <= 6'd4;
            r_rcon     <= 8'h01;
            r_table[0] <= i_key_in;
            r_rk_valid <= 1'b1;
            r_rk_index <= 4'd0;
            r_rk_out   <= i_key_in;
          end
        end
        S_EXPAND: begin
          r_w0  <= r_w1;
          r_w1  <= r_w2;
          r_w2  <= r_w3;
          r_w3  <= w_new;
          r_cnt <= r_cnt + 6'd1;
          if (w_first_of_round) r_rcon <= w_rcon_next;
          if (w_last_of_round) begin
            r_table[r_cnt[5:2]] <= {r_w1, r_w2, r_w3, w_new};
            r_rk_valid          <= 1'b1;
            r_rk_index          <= r_cnt[5:2];
            r_rk_out            <= {r_w1, r_w2, r_w3, w_new};
            r_done              <= w_last_word;
          end
        end
        S_LAST: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Combinational table read; addresses past round 10 read as zero.
  always_comb begin
    w_rk_data = '0;
    if (i_rk_addr <= 4'd10) w_rk_data = r_table[i_rk_addr];
  end

  assign o_rk_valid = r_rk_valid;
  assign o_rk_index = r_rk_index;
  assign o_rk_out   = r_rk_out;
  assign o_done     = r_done;
  assign o_rk_data  = w_rk_data;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: fixed FIPS-197 / zero-key vectors
// plus random keys checked against a key-schedule model that derives its S-box
// from GF(2^8) inversion and the AES affine map.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_key_in = '0;
  logic [3:0]   i_rk_addr = '0;
  logic         o_busy;
  logic         o_rk_valid;
  logic [3:0]   o_rk_index;
  logic [127:0] o_rk_out;
  logic         o_done;
  logic [127:0] o_rk_data;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  logic         cap_valid [43];
  logic         cap_done  [43];
  logic         cap_busy  [43];
  logic [3:0]   cap_index [43];
  logic [127:0] cap_out   [43];
  logic [127:0] cap_data  [43];

  aes_key_expansion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_key_in   (i_key_in),
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .o_rk_index (o_rk_index),
    .o_rk_out   (o_rk_out),
    .o_done     (o_done),
    .i_rk_addr  (i_rk_addr),
    .o_rk_data  (o_rk_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++)
      exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts a run (the current cycle becomes cycle 0) and records cycles 1..42.
  // Optional start pulses carrying alt_key are raised in cycles pa and pb.
  // The table address follows the round being streamed. Ends in cycle 42.
  task automatic capture_run(input logic [127:0] key, input int pa, input int pb,
                             input logic [127:0] alt_key);
    i_key_in = key;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      i_rk_addr = 4'((c - 1) / 4);
      #1;
      cap_valid[c] = o_rk_valid;
      cap_done[c]  = o_done;
      cap_busy[c]  = o_busy;
      cap_index[c] = o_rk_index;
      cap_out[c]   = o_rk_out;
      cap_data[c]  = o_rk_data;
      if (c == pa || c == pb) begin
        i_start  = 1'b1;
        i_key_in = alt_key;
      end
      if (c < 42) begin
        @(posedge clk); #1;
        i_start = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rk_addr = 4'd0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_rk_valid); end
    checks++; if (o_rk_index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", o_rk_index); end
    checks++; if (o_rk_out !== 128'h0) begin errors++; $display("FAIL reset_out: got %h want 0", o_rk_out); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    for (int a = 0; a < 16; a += 5) begin
      i_rk_addr = 4'(a);
      #1;
      checks++;
      if (o_rk_data !== 128'h0) begin errors++; $display("FAIL reset_table[%0d]: got %h want 0", a, o_rk_data); end
    end
  endtask

  task automatic test_fips();
    model_expand(FIPS_KEY);
    capture_run(FIPS_KEY, -1, -1, '0);
    checks++; if (cap_out[1] !== FIPS_KEY) begin errors++; $display("FAIL fips_rk0: got %h want %h", cap_out[1], FIPS_KEY); end
    checks++; if (cap_out[5] !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1: got %h want %h", cap_out[5], FIPS_RK1); end
    checks++; if (cap_out[41] !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10: got %h want %h", cap_out[41], FIPS_RK10); end
    checks++; if (cap_done[41] !== 1'b1) begin errors++; $display("FAIL fips_done41: got %b want 1", cap_done[41]); end
    checks++; if (cap_done[40] !== 1'b0 || cap_done[42] !== 1'b0) begin
      errors++; $display("FAIL fips_done_width: got c40=%b c42=%b want 0 0", cap_done[40], cap_done[42]); end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (cap_out[4*k+1] !== exp_rk[k]) begin
        errors++; $display("FAIL fips_model_rk%0d: got %h want %h", k, cap_out[4*k+1], exp_rk[k]); end
    end
  endtask

  task automatic test_zero_key();
    model_expand(128'h0);
    capture_run(128'h0, -1, -1, '0);
    checks++; if (cap_out[5] !== ZERO_RK1) begin errors++; $display("FAIL zero_rk1: got %h want %h", cap_out[5], ZERO_RK1); end
    checks++; if (cap_out[41] !== ZERO_RK10) begin errors++; $display("FAIL zero_rk10: got %h want %h", cap_out[41], ZERO_RK10); end
    i_rk_addr = 4'd0; #1;
    checks++; if (o_rk_data !== 128'h0) begin errors++; $display("FAIL zero_table0: got %h want 0", o_rk_data); end
    i_rk_addr = 4'd1; #1;
    checks++; if (o_rk_data !== ZERO_RK1) begin errors++; $display("FAIL zero_table1: got %h want %h", o_rk_data, ZERO_RK1); end
    i_rk_addr = 4'd10; #1;
    checks++; if (o_rk_data !== ZERO_RK10) begin errors++; $display("FAIL zero_table10: got %h want %h", o_rk_data, ZERO_RK10); end
    i_rk_addr = 4'd5; #1;
    checks++; if (o_rk_data !== exp_rk[5]) begin errors++; $display("FAIL zero_table5: got %h want %h", o_rk_data, exp_rk[5]); end
    i_rk_addr = 4'd12; #1;
    checks++; if (o_rk_data !== 128'h0) begin errors++; $display("FAIL zero_table12: got %h want 0", o_rk_data); end
  endtask

  task automatic test_stream();
    logic [127:0] key;
    logic         exp_v;
    int           nvalid;
    for (int run = 0; run < 3; run++) begin
      key = rand_key();
      model_expand(key);
      repeat (run) @(posedge clk);
      #1;
      capture_run(key, -1, -1, '0);
      nvalid = 0;
      for (int c = 1; c <= 42; c++) begin
        exp_v = ((c % 4) == 1) && (c <= 41);
        if (cap_valid[c] === 1'b1) nvalid++;
        checks++;
        if (cap_valid[c] !== exp_v) begin
          errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, cap_valid[c], exp_v); end
        if (exp_v) begin
          checks++;
          if (cap_index[c] !== 4'((c - 1) / 4)) begin
            errors++; $display("FAIL stream_index c%0d: got %0d want %0d", c, cap_index[c], (c - 1) / 4); end
          checks++;
          if (cap_out[c] !== exp_rk[(c - 1) / 4]) begin
            errors++; $display("FAIL stream_out c%0d: got %h want %h", c, cap_out[c], exp_rk[(c - 1) / 4]); end
        end
        checks++;
        if (cap_done[c] !== (c == 41)) begin
          errors++; $display("FAIL stream_done c%0d: got %b want %b", c, cap_done[c], (c == 41)); end
        checks++;
        if (cap_busy[c] !== (c <= 41)) begin
          errors++; $display("FAIL stream_busy c%0d: got %b want %b", c, cap_busy[c], (c <= 41)); end
        checks++;
        if (cap_data[c] !== exp_rk[(c - 1) / 4]) begin
          errors++; $display("FAIL stream_table c%0d: got %h want %h", c, cap_data[c], exp_rk[(c - 1) / 4]); end
      end
      checks++;
      if (nvalid != 11) begin errors++; $display("FAIL stream_valid_count: got %0d want 11", nvalid); end
      for (int a = 0; a < 16; a++) begin
        i_rk_addr = 4'(a); #1;
        checks++;
        if (o_rk_data !== ((a <= 10) ? exp_rk[a] : 128'h0)) begin
          errors++; $display("FAIL stream_table_sweep[%0d]: got %h want %h", a, o_rk_data,
                             ((a <= 10) ? exp_rk[a] : 128'h0)); end
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] key;
    logic [127:0] alt;
    logic [127:0] key2;
    key  = rand_key();
    alt  = ~key;
    key2 = rand_key();
    model_expand(key);
    capture_run(key, 10, 41, alt);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (cap_out[4*k+1] !== exp_rk[k] || cap_valid[4*k+1] !== 1'b1) begin
        errors++; $display("FAIL busy_ignore_rk%0d: got %h v=%b want %h v=1", k, cap_out[4*k+1], cap_valid[4*k+1], exp_rk[k]); end
    end
    checks++; if (cap_busy[42] !== 1'b0) begin errors++; $display("FAIL busy_drop42: got %b want 0", cap_busy[42]); end
    checks++; if (cap_valid[42] !== 1'b0) begin errors++; $display("FAIL busy_no_restart42: got %b want 0", cap_valid[42]); end
    model_expand(key2);
    capture_run(key2, -1, -1, '0);
    checks++; if (cap_out[1] !== key2) begin errors++; $display("FAIL busy_next_rk0: got %h want %h", cap_out[1], key2); end
    checks++; if (cap_out[41] !== exp_rk[10]) begin errors++; $display("FAIL busy_next_rk10: got %h want %h", cap_out[41], exp_rk[10]); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] key;
    int           seen;
    key = rand_key();
    i_key_in = key;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", o_busy); end
    i_rk_addr = 4'd0;
    rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", o_busy); end
    checks++; if (o_rk_valid !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL mid_valid_done: got %b %b want 0 0", o_rk_valid, o_done); end
    checks++; if (o_rk_out !== 128'h0 || o_rk_index !== 4'd0) begin
      errors++; $display("FAIL mid_out: got %h idx %0d want 0", o_rk_out, o_rk_index); end
    checks++; if (o_rk_data !== 128'h0) begin errors++; $display("FAIL mid_table0: got %h want 0", o_rk_data); end
    i_rk_addr = 4'd3; #1;
    checks++; if (o_rk_data !== 128'h0) begin errors++; $display("FAIL mid_table3: got %h want 0", o_rk_data); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_rk_valid !== 1'b0 || o_busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_partial: got %0d active cycles want 0", seen); end
    model_expand(FIPS_KEY);
    capture_run(FIPS_KEY, -1, -1, '0);
    checks++; if (cap_out[1] !== FIPS_KEY || cap_valid[1] !== 1'b1) begin
      errors++; $display("FAIL mid_rerun_rk0: got %h want %h", cap_out[1], FIPS_KEY); end
    checks++; if (cap_out[5] !== FIPS_RK1 || cap_valid[5] !== 1'b1) begin
      errors++; $display("FAIL mid_rerun_rk1: got %h want %h", cap_out[5], FIPS_RK1); end
    checks++; if (cap_out[41] !== FIPS_RK10 || cap_done[41] !== 1'b1) begin
      errors++; $display("FAIL mid_rerun_rk10: got %h done %b want %h done 1", cap_out[41], cap_done[41], FIPS_RK10); end
  endtask

  task automatic test_back_to_back();
    capture_run(128'h0, -1, -1, '0);
    checks++; if (cap_out[41] !== ZERO_RK10) begin errors++; $display("FAIL b2b_first_rk10: got %h want %h", cap_out[41], ZERO_RK10); end
    model_expand(FIPS_KEY);
    capture_run(FIPS_KEY, -1, -1, '0);
    checks++; if (cap_out[5] !== FIPS_RK1) begin errors++; $display("FAIL b2b_second_rk1: got %h want %h", cap_out[5], FIPS_RK1); end
    checks++; if (cap_out[41] !== FIPS_RK10) begin errors++; $display("FAIL b2b_second_rk10: got %h want %h", cap_out[41], FIPS_RK10); end
    checks++; if (cap_out[21] !== exp_rk[5]) begin errors++; $display("FAIL b2b_second_rk5: got %h want %h", cap_out[21], exp_rk[5]); end
  endtask

  initial begin
    build_sbox();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_fips();
    @(posedge clk); #1;
    test_zero_key();
    @(posedge clk); #1;
    test_stream();
    @(posedge clk); #1;
    test_start_while_busy();
    @(posedge clk); #1;
    test_reset_mid();
    @(posedge clk); #1;
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
